// File: rtl/mem_bus_responder_pkg.sv
// rtl/mem_bus_responder_pkg.sv - shared state encodings and constants for the memory bus responder
package mem_bus_responder_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_BURST,
    R_DONE
  } rd_state_e;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_e;

  localparam int unsigned WORD_OFS_W        = 2;
  localparam int unsigned DEF_READ_LATENCY  = 2;
  localparam int unsigned DEF_WRITE_LATENCY = 1;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[WORD_OFS_W-1:0] != '0;
  endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// rtl/mem_bus_responder_if.sv - cache-to-bus read/write port bundle
interface mem_bus_responder_if;
  logic        axi_ce_i;
  logic        axi_ren_i;
  logic        axi_rready_i;
  logic [31:0] axi_raddr_i;
  logic [3:0]  axi_rlen_i;
  logic [31:0] axi_rdata_o;
  logic        axi_rvalid_o;
  logic        axi_wen_i;
  logic [31:0] axi_waddr_i;
  logic [31:0] axi_wdata_i;
  logic        axi_wvalid_i;
  logic        axi_wlast_i;
  logic [3:0]  axi_wlen_i;
  logic        axi_bvalid_o;
  logic        proto_err_o;

  modport master (
    output axi_ce_i, axi_ren_i, axi_rready_i, axi_raddr_i, axi_rlen_i,
    output axi_wen_i, axi_waddr_i, axi_wdata_i, axi_wvalid_i, axi_wlast_i, axi_wlen_i,
    input  axi_rdata_o, axi_rvalid_o, axi_bvalid_o, proto_err_o
  );

  modport slave (
    input  axi_ce_i, axi_ren_i, axi_rready_i, axi_raddr_i, axi_rlen_i,
    input  axi_wen_i, axi_waddr_i, axi_wdata_i, axi_wvalid_i, axi_wlast_i, axi_wlen_i,
    output axi_rdata_o, axi_rvalid_o, axi_bvalid_o, proto_err_o
  );
endinterface

// File: rtl/mem_bus_resp_ram.sv
// rtl/mem_bus_resp_ram.sv - simple dual-port word RAM, registered read-first read port
module mem_bus_resp_ram #(
  parameter int unsigned AW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // The combinational read precedes the write's NBA, so a same-edge collision returns old data.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - RAM-backed bus endpoint with burst reads and single-word writes
// Optional protocol checker: MEM_BUS_RESP_PROTO_CHECK_EN.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int unsigned MEM_AW        = 14,
  parameter int unsigned READ_LATENCY  = DEF_READ_LATENCY,
  parameter int unsigned WRITE_LATENCY = DEF_WRITE_LATENCY
) (
  input logic               clk,
  input logic               rst,
  mem_bus_responder_if.slave bus
);

  rd_state_e         rd_state_q, rd_state_d;
  logic [MEM_AW-1:0] idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        wait_q, wait_d;
  logic              rvalid_q, rvalid_d;

  wr_state_e         wr_state_q, wr_state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              bvalid_q, bvalid_d;

  logic              rd_accept;
  logic              wr_accept;
  logic              issue_slot;
  logic [MEM_AW-1:0] cur_idx;
  logic [3:0]        cur_cnt;
  logic [3:0]        cur_len;
  logic              ram_re;
  logic [MEM_AW-1:0] ram_raddr;
  logic [31:0]       ram_rdata;

  assign rd_accept = ~rst & (rd_state_q == R_IDLE) & bus.axi_ce_i & bus.axi_ren_i;
  assign wr_accept = ~rst & (wr_state_q == W_IDLE) & bus.axi_ce_i & bus.axi_wen_i & bus.axi_wvalid_i;

  always_comb begin
    rd_state_d = rd_state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    wait_d     = wait_q;
    rvalid_d   = 1'b0;
    ram_re     = 1'b0;
    ram_raddr  = idx_q;
    issue_slot = 1'b0;
    cur_idx    = idx_q;
    cur_cnt    = cnt_q;
    cur_len    = len_q;

    case (rd_state_q)
      R_IDLE: begin
        if (rd_accept) begin
          cur_idx = bus.axi_raddr_i[MEM_AW+WORD_OFS_W-1:WORD_OFS_W];
          cur_cnt = 4'd0;
          cur_len = bus.axi_rlen_i;
          idx_d   = cur_idx;
          cnt_d   = cur_cnt;
          len_d   = cur_len;
          if (READ_LATENCY == 1) begin
            issue_slot = 1'b1;
          end else begin
            rd_state_d = R_WAIT;
            wait_d     = 4'(READ_LATENCY - 2);
          end
        end
      end
      R_WAIT: begin
        if (wait_q == 4'd0) issue_slot = 1'b1;
        else                wait_d     = wait_q - 4'd1;
      end
      R_BURST: issue_slot = 1'b1;
      R_DONE:  rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase

    // A beat is read from RAM at the edge it is issued and appears on the bus the next cycle.
    if (issue_slot) begin
      rd_state_d = R_BURST;
      if (bus.axi_rready_i) begin
        ram_re    = 1'b1;
        ram_raddr = cur_idx;
        rvalid_d  = 1'b1;
        if (cur_cnt == cur_len) begin
          rd_state_d = R_DONE;
        end else begin
          idx_d = cur_idx + 1'b1;
          cnt_d = cur_cnt + 4'd1;
        end
      end
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wcnt_d     = wcnt_q;
    bvalid_d   = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (wr_accept) begin
          wr_state_d = W_RESP;
          wcnt_d     = 4'(WRITE_LATENCY - 1);
          bvalid_d   = (WRITE_LATENCY == 1);
        end
      end
      W_RESP: begin
        if (wcnt_q == 4'd0) begin
          wr_state_d = W_IDLE;
        end else begin
          wcnt_d   = wcnt_q - 4'd1;
          bvalid_d = (wcnt_q == 4'd1);
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      wait_q     <= '0;
      rvalid_q   <= 1'b0;
      wr_state_q <= W_IDLE;
      wcnt_q     <= '0;
      bvalid_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      wait_q     <= wait_d;
      rvalid_q   <= rvalid_d;
      wr_state_q <= wr_state_d;
      wcnt_q     <= wcnt_d;
      bvalid_q   <= bvalid_d;
    end
  end

  mem_bus_resp_ram #(
    .AW (MEM_AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_accept),
    .waddr (bus.axi_waddr_i[MEM_AW+WORD_OFS_W-1:WORD_OFS_W]),
    .wdata (bus.axi_wdata_i),
    .re    (ram_re & ~rst),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign bus.axi_rdata_o  = ram_rdata;
  assign bus.axi_rvalid_o = rvalid_q;
  assign bus.axi_bvalid_o = bvalid_q;

`ifdef MEM_BUS_RESP_PROTO_CHECK_EN
  logic proto_err_q, proto_err_d;

  always_comb begin
    proto_err_d = proto_err_q;
    if (wr_accept & ((bus.axi_wlen_i != 4'd0) | ~bus.axi_wlast_i)) proto_err_d = 1'b1;
    if (wr_accept & misaligned(bus.axi_waddr_i))                   proto_err_d = 1'b1;
    if (rd_accept & misaligned(bus.axi_raddr_i))                   proto_err_d = 1'b1;
    if (~bus.axi_ce_i & (bus.axi_ren_i | bus.axi_wen_i))           proto_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) proto_err_q <= 1'b0;
    else     proto_err_q <= proto_err_d;
  end

  assign bus.proto_err_o = proto_err_q;
`else
  assign bus.proto_err_o = 1'b0;
`endif

  // Upper address bits alias; offset, wlen and wlast only matter to the checker.
  logic unused_bits;
  assign unused_bits = ^{bus.axi_raddr_i[31:MEM_AW+WORD_OFS_W], bus.axi_raddr_i[WORD_OFS_W-1:0],
                         bus.axi_waddr_i[31:MEM_AW+WORD_OFS_W], bus.axi_waddr_i[WORD_OFS_W-1:0],
                         bus.axi_wlen_i, bus.axi_wlast_i};

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - directed bench with a cycle-level reference model of the responder
module tb_mem_bus_responder;

  localparam int MEM_AW = 14;
  localparam int DEPTH  = 2 ** MEM_AW;
  localparam int RL     = 2;
  localparam int WL     = 1;
  localparam int NCYC   = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_responder_if bus();

  mem_bus_responder #(
    .MEM_AW        (MEM_AW),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  logic        rv_log [NCYC];
  logic [31:0] rd_log [NCYC];
  logic        bv_log [NCYC];
  logic        pe_log [NCYC];
  logic [31:0] got [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: spec-level view with a word array, an outstanding-read record and write timers.
  logic [31:0] mmem [int];
  bit          rbusy, m_turn, m_fresh;
  int          m_wait, m_left, m_idx;
  int          b_at, w_busy_until;
  bit          beat_m;
  logic [31:0] bdata_m;
  logic        exp_rv, exp_bv, exp_err, exp_rd_chk;
  logic [31:0] exp_rd;

  always @(posedge clk) begin
    beat_m  = 1'b0;
    bdata_m = '0;
    if (rst) begin
      rbusy = 0; m_turn = 0; m_fresh = 1;
      b_at = -1; w_busy_until = -1;
      exp_rv = 0; exp_rd = '0; exp_bv = 0; exp_err = 0;
    end else begin
      if (!rbusy) begin
        if (bus.axi_ce_i && bus.axi_ren_i) begin
          rbusy  = 1;
          m_turn = 0;
          m_idx  = int'((bus.axi_raddr_i >> 2) & (DEPTH - 1));
          m_left = int'(bus.axi_rlen_i) + 1;
          m_wait = RL - 1;
`ifdef MEM_BUS_RESP_PROTO_CHECK_EN
          if (bus.axi_raddr_i[1:0] != 2'b00) exp_err = 1;
`endif
        end
      end else if (m_turn) begin
        rbusy  = 0;
        m_turn = 0;
      end else if (m_wait > 0) begin
        m_wait--;
      end
      if (rbusy && !m_turn && m_wait == 0 && bus.axi_rready_i) begin
        beat_m  = 1;
        bdata_m = mmem.exists(m_idx) ? mmem[m_idx] : 32'h0;
        m_idx   = (m_idx + 1) % DEPTH;
        m_left--;
        if (m_left == 0) m_turn = 1;
      end
      if (bus.axi_ce_i && bus.axi_wen_i && bus.axi_wvalid_i && cyc > w_busy_until) begin
        mmem[int'((bus.axi_waddr_i >> 2) & (DEPTH - 1))] = bus.axi_wdata_i;
        b_at         = cyc + WL;
        w_busy_until = cyc + WL;
`ifdef MEM_BUS_RESP_PROTO_CHECK_EN
        if (bus.axi_wlen_i != 4'd0 || !bus.axi_wlast_i || bus.axi_waddr_i[1:0] != 2'b00) exp_err = 1;
`endif
      end
`ifdef MEM_BUS_RESP_PROTO_CHECK_EN
      if (!bus.axi_ce_i && (bus.axi_ren_i || bus.axi_wen_i)) exp_err = 1;
`endif
      exp_rv = beat_m;
      exp_bv = (cyc + 1 == b_at);
      if (beat_m) begin
        exp_rd  = bdata_m;
        m_fresh = 0;
      end
    end
    exp_rd_chk = beat_m || m_fresh;
    cyc++;
  end

  always @(negedge clk) begin
    if (cyc < NCYC) begin
      rv_log[cyc] = bus.axi_rvalid_o;
      rd_log[cyc] = bus.axi_rdata_o;
      bv_log[cyc] = bus.axi_bvalid_o;
      pe_log[cyc] = bus.proto_err_o;
    end
    if (chk_en) begin
      chk("rvalid", {31'b0, bus.axi_rvalid_o}, {31'b0, exp_rv});
      if (exp_rd_chk) chk("rdata", bus.axi_rdata_o, exp_rd);
      chk("bvalid", {31'b0, bus.axi_bvalid_o}, {31'b0, exp_bv});
      chk("proto_err", {31'b0, bus.proto_err_o}, {31'b0, exp_err});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.axi_ce_i     = 1'b1;
    bus.axi_ren_i    = 1'b0;
    bus.axi_rready_i = 1'b1;
    bus.axi_raddr_i  = '0;
    bus.axi_rlen_i   = '0;
    bus.axi_wen_i    = 1'b0;
    bus.axi_waddr_i  = '0;
    bus.axi_wdata_i  = '0;
    bus.axi_wvalid_i = 1'b0;
    bus.axi_wlast_i  = 1'b0;
    bus.axi_wlen_i   = '0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] len);
    bus.axi_wen_i    = 1'b1;
    bus.axi_wvalid_i = 1'b1;
    bus.axi_wlast_i  = 1'b1;
    bus.axi_wlen_i   = len;
    bus.axi_waddr_i  = a;
    bus.axi_wdata_i  = d;
    tick();
    bus.axi_wen_i    = 1'b0;
    bus.axi_wvalid_i = 1'b0;
    bus.axi_wlast_i  = 1'b0;
    bus.axi_wlen_i   = '0;
    tick();
    tick();
  endtask

  task automatic start_read(input logic [31:0] a, input logic [3:0] len);
    bus.axi_ren_i   = 1'b1;
    bus.axi_raddr_i = a;
    bus.axi_rlen_i  = len;
  endtask

  task automatic collect(input int a, input int b);
    got.delete();
    for (int i = a; i <= b; i++) if (rv_log[i]) got.push_back(rd_log[i]);
  endtask

  task automatic chk_burst(input string tag, input logic [31:0] base, input int n);
    chk({tag, " beat count"}, got.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s beat%0d", tag, i), (i < got.size()) ? got[i] : 32'hFFFF_FFFF, base + i);
  endtask

  int c;

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    chk_en = 1'b1;
    chk("reset rvalid", {31'b0, bus.axi_rvalid_o}, 0);
    chk("reset rdata", bus.axi_rdata_o, 0);
    chk("reset bvalid", {31'b0, bus.axi_bvalid_o}, 0);
    chk("reset proto_err", {31'b0, bus.proto_err_o}, 0);
    rst = 1'b0;
    tick();

    // Single write, then a one-beat read of it.
    c = cyc;
    do_write(32'h40, 32'hDEAD_BEEF, 4'd0);
    chk("wr bvalid c0", {31'b0, bv_log[c]}, 0);
    chk("wr bvalid c1", {31'b0, bv_log[c+1]}, 1);
    chk("wr bvalid c2", {31'b0, bv_log[c+2]}, 0);

    c = cyc;
    start_read(32'h40, 4'd0);
    tick();
    bus.axi_ren_i = 1'b0;
    repeat (6) tick();
    chk("rd1 rvalid c1", {31'b0, rv_log[c+1]}, 0);
    chk("rd1 rvalid c2", {31'b0, rv_log[c+2]}, 1);
    chk("rd1 rdata c2", rd_log[c+2], 32'hDEAD_BEEF);
    collect(c, c + 6);
    chk("rd1 beat count", got.size(), 1);

    // Preload and 8-beat burst with ren held through the turnaround cycle.
    for (int i = 0; i < 8; i++) do_write(32'h100 + 4 * i, 32'h1000 + i, 4'd0);
    c = cyc;
    start_read(32'h100, 4'd7);
    repeat (10) tick();
    bus.axi_ren_i = 1'b0;
    repeat (8) tick();
    collect(c, c + 17);
    chk_burst("burst", 32'h1000, 8);
    chk("burst first c2", {31'b0, rv_log[c+2]}, 1);
    chk("burst after c10", {31'b0, rv_log[c+10]}, 0);

    // Two rready-low cycles just before beat 3 is issued.
    c = cyc;
    start_read(32'h100, 4'd7);
    tick();
    bus.axi_ren_i = 1'b0;
    repeat (3) tick();
    bus.axi_rready_i = 1'b0;
    repeat (2) tick();
    bus.axi_rready_i = 1'b1;
    repeat (10) tick();
    collect(c, c + 15);
    chk_burst("gap", 32'h1000, 8);
    chk("gap c5", {31'b0, rv_log[c+5]}, 0);
    chk("gap c6", {31'b0, rv_log[c+6]}, 0);
    chk("gap beat3 c7", rd_log[c+7], 32'h1003);

    // Write to 0x104 on the edge that issues its read beat.
    c = cyc;
    start_read(32'h100, 4'd1);
    tick();
    bus.axi_ren_i = 1'b0;
    tick();
    do_write(32'h104, 32'h55, 4'd0);
    repeat (3) tick();
    chk("coll rvalid c3", {31'b0, rv_log[c+3]}, 1);
    chk("coll old data", rd_log[c+3], 32'h1001);
    c = cyc;
    start_read(32'h104, 4'd0);
    tick();
    bus.axi_ren_i = 1'b0;
    repeat (5) tick();
    chk("coll new data", rd_log[c+2], 32'h55);

    // Reset during beat 4 of an 8-beat burst.
    c = cyc;
    start_read(32'h100, 4'd7);
    tick();
    bus.axi_ren_i = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("rstmid beat4", rd_log[c+6], 32'h1004);
    chk("rstmid rvalid", {31'b0, rv_log[c+7]}, 0);
    chk("rstmid rdata", rd_log[c+7], 0);
    collect(c, c + 14);
    chk("rstmid beat count", got.size(), 5);
    c = cyc;
    start_read(32'h40, 4'd0);
    tick();
    bus.axi_ren_i = 1'b0;
    repeat (5) tick();
    chk("post-rst retained", rd_log[c+2], 32'hDEAD_BEEF);
    c = cyc;
    start_read(32'h104, 4'd1);
    tick();
    bus.axi_ren_i = 1'b0;
    repeat (6) tick();
    chk("post-rst 0x104", rd_log[c+2], 32'h55);
    chk("post-rst 0x108", rd_log[c+3], 32'h1002);

    // Protocol violations: wlen=1, then ren while ce is low.
    c = cyc;
    do_write(32'h200, 32'h77, 4'd1);
`ifdef MEM_BUS_RESP_PROTO_CHECK_EN
    chk("proto wlen c1", {31'b0, pe_log[c+1]}, 1);
    chk("proto wlen c2", {31'b0, pe_log[c+2]}, 1);
`else
    chk("proto wlen c1", {31'b0, pe_log[c+1]}, 0);
    chk("proto wlen c2", {31'b0, pe_log[c+2]}, 0);
`endif
    c = cyc;
    bus.axi_ce_i = 1'b0;
    start_read(32'h100, 4'd0);
    tick();
    bus.axi_ce_i  = 1'b1;
    bus.axi_ren_i = 1'b0;
    repeat (5) tick();
    collect(c, c + 5);
    chk("ce-low no beat", got.size(), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("proto cleared", {31'b0, bus.proto_err_o}, 0);
    repeat (3) tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
